// File: rtl/game_pkg.sv
// game_pkg: shared cell/grid types, directions and FSM states for the 2048 board blocks.
package game_pkg;
  localparam int GRID_N = 4;
  localparam logic [3:0] EMPTY = 4'd0;
  typedef logic [3:0] cell_t;
  typedef cell_t [GRID_N-1:0] line_t;
  typedef line_t [GRID_N-1:0] grid_t;
  typedef enum logic [1:0] {DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN} dir_t;
  typedef enum logic [1:0] {S_IDLE, S_PROC, S_DONE} state_t;
endpackage

// File: rtl/line_merger.sv
// line_merger: slides one oriented line toward index 0 and merges equal neighbours once.
module line_merger
  import game_pkg::*;
(
  input  line_t       line_in,
  output line_t       line_out,
  output logic        line_changed,
  output logic [16:0] line_score
);
  logic [4:0][3:0] c;
  logic [2:0] n;
  logic [1:0] p;
  logic skip;
  // c[4] stays empty so the last cell never finds a merge partner
  always_comb begin
    c = '0;
    n = '0;
    for (int i = 0; i < GRID_N; i++)
      if (line_in[2'(i)] != EMPTY) begin
        c[n] = line_in[2'(i)];
        n = n + 3'd1;
      end
    line_out = '0;
    line_score = '0;
    p = '0;
    skip = 1'b0;
    for (int i = 0; i < GRID_N; i++)
      if (skip) skip = 1'b0;
      else if (c[3'(i)] != EMPTY) begin
        if (c[3'(i)] == c[3'(i + 1)] && c[3'(i)] != 4'd15) begin
          line_out[p] = c[3'(i)] + 4'd1;
          line_score = line_score + (17'd2 << c[3'(i)]);
          skip = 1'b1;
        end else line_out[p] = c[3'(i)];
        p = p + 2'd1;
      end
  end
  assign line_changed = line_out != line_in;
endmodule

// File: rtl/grid_mover.sv
// grid_mover: 2048 move/merge engine, one oriented line per cycle through a shared line_merger.
module grid_mover
  import game_pkg::*;
#(
  parameter int WIN_EXP = 11,
  parameter int SCORE_W = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            dir,
  input  logic [3:0][3:0][3:0]  grid_in,
  output logic                  busy,
  output logic                  done,
  output logic [3:0][3:0][3:0]  grid_out,
  output logic                  changed,
  output logic [SCORE_W-1:0]    score_add,
  output logic                  won
);
  localparam cell_t WIN_C = cell_t'(WIN_EXP);
  state_t state, state_nx;
  logic [1:0] cnt;
  dir_t dir_r;
  grid_t work, work_nx;
  line_t lin, lout;
  logic chg, lchg, win_nx;
  logic [SCORE_W-1:0] acc, acc_nx;
  logic [16:0] lscore;
  line_merger u_merge (.line_in(lin), .line_out(lout), .line_changed(lchg), .line_score(lscore));
  // the same cell mapping serves extraction and write-back
  always_comb begin
    lin = '0;
    work_nx = work;
    for (int t = 0; t < GRID_N; t++) begin
      lin[2'(t)] = dir_r == DIR_LEFT  ? work[cnt][2'(t)] :
                   dir_r == DIR_RIGHT ? work[cnt][2'(3 - t)] :
                   dir_r == DIR_UP    ? work[2'(t)][cnt] : work[2'(3 - t)][cnt];
      if (dir_r == DIR_LEFT) work_nx[cnt][2'(t)] = lout[2'(t)];
      else if (dir_r == DIR_RIGHT) work_nx[cnt][2'(3 - t)] = lout[2'(t)];
      else if (dir_r == DIR_UP) work_nx[2'(t)][cnt] = lout[2'(t)];
      else work_nx[2'(3 - t)][cnt] = lout[2'(t)];
    end
    win_nx = 1'b0;
    for (int i = 0; i < GRID_N; i++)
      for (int j = 0; j < GRID_N; j++)
        win_nx = win_nx | (work_nx[2'(i)][2'(j)] >= WIN_C);
    acc_nx = acc + SCORE_W'(lscore);
  end
  always_comb begin
    state_nx = state == S_IDLE ? (start ? S_PROC : S_IDLE) :
               state == S_PROC ? (cnt == 2'd3 ? S_DONE : S_PROC) : S_IDLE;
  end
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_nx;
  // results are registered on the last line edge so they are valid throughout DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      dir_r <= DIR_LEFT;
      work <= '0;
      chg <= 1'b0;
      acc <= '0;
      grid_out <= '0;
      changed <= 1'b0;
      score_add <= '0;
      won <= 1'b0;
    end else if (state == S_IDLE && start) begin
      work <= grid_in;
      dir_r <= dir_t'(dir);
      cnt <= '0;
      chg <= 1'b0;
      acc <= '0;
    end else if (state == S_PROC) begin
      work <= work_nx;
      cnt <= cnt + 2'd1;
      chg <= chg | lchg;
      acc <= acc_nx;
      if (cnt == 2'd3) begin
        grid_out <= work_nx;
        changed <= chg | lchg;
        score_add <= acc_nx;
        won <= won | win_nx;
      end
    end
  end
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
endmodule
